pwm_avalon_ctrl: RTL
====================

Name: pwm_avalon_ctrl

Overview:
Avalon-MM slave controller that configures and sequences one downstream PWM core, which takes period, duty_cycle and reset_n inputs.
- Holds software-written shadow period/duty registers.
- Commits them to the core only at a PWM period boundary, so no glitched periods occur.
- Optionally ramps duty toward the target by a fixed step per period.
- Raises an interrupt at each period end.
- Keeps a mirror counter of the core's wrap rule to locate boundaries.

Parameters:
- ADDR_W, 3, Avalon word-address width.
- RST_PERIOD, 32'd999, reset value of shadow and active period.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- avs_address  in  ADDR_W  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed read latency 1
- avs_readdatavalid  out  1  high 1 cycle after avs_read
- irq  out  1  level interrupt
- pwm_period  out  32  active period to core
- pwm_duty  out  32  active duty to core
- pwm_rst_n  out  1  synchronous active-low hold of core; low while disabled

Behaviour:
- Register map (word addresses):
  - 0 CTRL: b0 EN, b1 RAMP_EN, b2 IRQ_EN.
  - 1 PERIOD (shadow).
  - 2 DUTY (shadow target).
  - 3 STEP.
  - 4 STATUS: b0 PEND_IRQ (write-1-to-clear), b1 RAMP_BUSY, b2 UPD_PENDING; read-only except b0.
  - 5 ACT_DUTY (RO).
  - 6 ACT_PERIOD (RO).
  - 7 reads 0.
  - Writes to RO or unused addresses are ignored.
- Reset values:
  - readdata, readdatavalid, irq: 0.
  - pwm_rst_n: 0. CTRL, DUTY, STEP, STATUS: 0.
  - PERIOD and pwm_period: RST_PERIOD. pwm_duty: 0. Mirror cnt: 0. State IDLE.
- Mirror counter cnt (32 bit):
  - Cleared while pwm_rst_n=0.
  - Otherwise: if cnt > pwm_period, cnt<=0; else cnt<=cnt+1 (natural wrap at 0xFFFFFFFF).
  - tick = pwm_rst_n & ((cnt > pwm_period) | (cnt == 32'hFFFFFFFF)); marks the last cycle of a period.
- Period length is pwm_period+2 cycles; for pwm_period = 0xFFFFFFFF it is 2^32 cycles.
- FSM IDLE -> RUN:
  - Taken on the cycle EN is written 1.
  - On that edge: pwm_period<=PERIOD; pwm_duty<=(RAMP_EN ? 0 : DUTY); UPD_PENDING<=0.
  - pwm_rst_n goes 1 on the same edge, i.e. the first cycle after the write.
- FSM RUN -> IDLE:
  - Taken on the cycle EN is written 0.
  - pwm_rst_n<=0 and cnt cleared next cycle.
  - pwm_period/pwm_duty hold their values.
  - Any pending update is discarded.
- Writes to PERIOD or DUTY in RUN set UPD_PENDING.
- On tick in RUN:
  - pwm_period<=PERIOD.
  - Duty update:
    - RAMP_EN=0 or STEP=0: pwm_duty<=DUTY.
    - Otherwise: if |DUTY-pwm_duty| <= STEP, pwm_duty<=DUTY; else pwm_duty moves by ±STEP toward DUTY.
    - Unsigned compare; no overflow or underflow past DUTY.
  - UPD_PENDING<=0.
  - PEND_IRQ<=1.
- Simultaneous tick and write to PERIOD/DUTY:
  - The tick commits the pre-write shadow value.
  - The write sets UPD_PENDING and applies at the next tick.
- Simultaneous tick and PEND_IRQ clear: set wins.
- RAMP_BUSY = RUN & RAMP_EN & (pwm_duty != DUTY).
- irq = IRQ_EN & PEND_IRQ, registered.
- A read returns the register value sampled in the read cycle, valid the next cycle.
- Simultaneous read and write to the same address returns the old value.
- Reset asserted mid-operation returns every item to its reset value immediately.

Optional Feature:
- Macro PWM_CTRL_RAMP_EN.
- Defined: STEP register, RAMP_EN bit and ramp stepping are implemented as above.
- Undefined:
  - No STEP storage; address 3 reads 0.
  - CTRL b1 reads 0 and is ignored.
  - RAMP_BUSY is always 0.
  - Every tick loads pwm_duty<=DUTY directly; enable loads pwm_duty<=DUTY.

Test Plan:
- Reset -> pwm_rst_n=0, pwm_period=999, pwm_duty=0, irq=0. Read ACT_PERIOD -> 999 with readdatavalid one cycle after read.
- PERIOD=8, DUTY=3, CTRL=0x5 -> pwm_rst_n=1 next cycle, tick every 10 cycles, irq rises after first tick. Write STATUS=1 -> irq low until next tick.
- In RUN (period 8), write DUTY=6 mid-period -> pwm_duty stays 3 until tick, then 6. UPD_PENDING 1->0 at that tick.
- RAMP (macro on): PERIOD=8, STEP=2, DUTY=7, CTRL=0x3 -> pwm_duty 0,2,4,6,7 across successive ticks. RAMP_BUSY clears at 7. Then write DUTY=1 -> 5,3,1.
- DUTY write issued in the exact tick cycle -> old value committed, new value committed at following tick. W1C in the tick cycle -> PEND_IRQ stays 1.
- CTRL=0 during RUN, then reset_n pulse mid-period -> pwm_rst_n=0, cnt=0, no further ticks. After reset, all outputs return to reset values.

Source files
------------

// File: rtl/pwm_avalon_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_avalon_ctrl
//  Purpose  : Avalon-MM slave that configures and sequences one downstream
//             PWM core. Software writes shadow period/duty registers. These
//             are committed to the core only at a PWM period boundary, so the
//             core never sees a glitched period. An optional duty ramp moves
//             the active duty toward the target by STEP once per period. An
//             interrupt is raised at every period end. A mirror counter
//             replicates the core's wrap rule so that boundaries are known
//             locally.
//  Ports    : clk, reset_n (async, active-low)
//             avs_address/avs_read/avs_write/avs_writedata  - slave request
//             avs_readdata/avs_readdatavalid                 - read latency 1
//             irq                                            - level interrupt
//             pwm_period/pwm_duty/pwm_rst_n                  - core controls
//  Macro    : PWM_CTRL_RAMP_EN - when defined, the STEP register, the CTRL
//             RAMP_EN bit and duty ramping are built. When undefined, address
//             3 reads 0, CTRL b1 reads 0 and every commit loads DUTY directly.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_avalon_ctrl #(
  parameter int          ADDR_W     = 3,
  parameter logic [31:0] RST_PERIOD = 32'd999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq,
  output logic [31:0]       pwm_period,
  output logic [31:0]       pwm_duty,
  output logic              pwm_rst_n
);

  localparam logic [ADDR_W-1:0] c_addr_ctrl   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_addr_period = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_duty   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_addr_step   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] c_addr_status = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_addr_act_d  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] c_addr_act_p  = ADDR_W'(6);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_en;
  logic        r_irq_en;
  logic        r_ramp_en;
  logic [31:0] r_period;
  logic [31:0] r_duty;
  logic [31:0] r_step;
  logic        r_pend_irq;
  logic        r_upd_pending;
  logic [31:0] r_cnt;

  logic        w_wr_ctrl;
  logic        w_wr_period;
  logic        w_wr_duty;
  logic        w_wr_status;
  logic        w_go;
  logic        w_stop;
  logic        w_tick;
  logic        w_commit;
  logic [31:0] w_duty_tick;
  logic [31:0] w_duty_go;
  logic        w_ramp_busy;
  logic [31:0] w_rdata;

  // --------------------------------------------------------------------------
  // Write decode
  // --------------------------------------------------------------------------
  assign w_wr_ctrl   = avs_write && (avs_address == c_addr_ctrl);
  assign w_wr_period = avs_write && (avs_address == c_addr_period);
  assign w_wr_duty   = avs_write && (avs_address == c_addr_duty);
  assign w_wr_status = avs_write && (avs_address == c_addr_status);

  assign w_go   = (r_state == S_IDLE) && w_wr_ctrl &&  avs_writedata[0];
  assign w_stop = (r_state == S_RUN)  && w_wr_ctrl && !avs_writedata[0];

  // Last cycle of a period. The all-ones term covers pwm_period = 2^32-1,
  // where the counter never exceeds the period and wraps naturally.
  assign w_tick = pwm_rst_n && ((r_cnt > pwm_period) || (r_cnt == 32'hFFFF_FFFF));

  // A disable in the tick cycle wins: the pending update is discarded.
  assign w_commit = (r_state == S_RUN) && w_tick && !w_stop;

  // --------------------------------------------------------------------------
  // Duty selection for enable and for period-boundary commits
  // --------------------------------------------------------------------------
`ifdef PWM_CTRL_RAMP_EN
  logic [31:0] w_dist;
  logic        w_ramp_on;

  assign w_ramp_on = r_ramp_en && (r_step != 32'd0);
  assign w_dist    = (r_duty >= pwm_duty) ? (r_duty - pwm_duty) : (pwm_duty - r_duty);

  // When the distance exceeds STEP the moved value stays strictly on the near
  // side of DUTY, so the add/subtract can neither overflow nor underflow.
  always_comb begin
    w_duty_tick = r_duty;
    if (w_ramp_on && (w_dist > r_step)) begin
      if (r_duty > pwm_duty) begin
        w_duty_tick = pwm_duty + r_step;
      end else begin
        w_duty_tick = pwm_duty - r_step;
      end
    end
  end

  // Ramping always starts from zero; the RAMP_EN bit being written now counts.
  assign w_duty_go   = avs_writedata[1] ? 32'd0 : r_duty;
  assign w_ramp_busy = (r_state == S_RUN) && r_ramp_en && (pwm_duty != r_duty);
`else
  assign w_duty_tick = r_duty;
  assign w_duty_go   = r_duty;
  assign w_ramp_busy = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_go)   w_state_nxt = S_RUN;
      S_RUN:  if (w_stop) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Software-visible registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en          <= 1'b0;
      r_irq_en      <= 1'b0;
      r_period      <= RST_PERIOD;
      r_duty        <= 32'd0;
      r_pend_irq    <= 1'b0;
      r_upd_pending <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= avs_writedata[0];
        r_irq_en <= avs_writedata[2];
      end
      if (w_wr_period) r_period <= avs_writedata;
      if (w_wr_duty)   r_duty   <= avs_writedata;

      // A boundary setting the pending flag beats a simultaneous clear.
      if (w_commit) begin
        r_pend_irq <= 1'b1;
      end else if (w_wr_status && avs_writedata[0]) begin
        r_pend_irq <= 1'b0;
      end

      // A shadow write in the commit cycle must survive to the next boundary.
      if (w_go || w_stop) begin
        r_upd_pending <= 1'b0;
      end else if ((r_state == S_RUN) && (w_wr_period || w_wr_duty)) begin
        r_upd_pending <= 1'b1;
      end else if (w_commit) begin
        r_upd_pending <= 1'b0;
      end
    end
  end

`ifdef PWM_CTRL_RAMP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ramp_en <= 1'b0;
      r_step    <= 32'd0;
    end else begin
      if (w_wr_ctrl) r_ramp_en <= avs_writedata[1];
      if (avs_write && (avs_address == c_addr_step)) r_step <= avs_writedata;
    end
  end
`else
  assign r_ramp_en = 1'b0;
  assign r_step    = 32'd0;
`endif

  // --------------------------------------------------------------------------
  // Core controls and mirror counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_period <= RST_PERIOD;
      pwm_duty   <= 32'd0;
      pwm_rst_n  <= 1'b0;
      r_cnt      <= 32'd0;
      irq        <= 1'b0;
    end else begin
      pwm_rst_n <= (w_state_nxt == S_RUN);

      if (w_go) begin
        pwm_period <= r_period;
        pwm_duty   <= w_duty_go;
      end else if (w_commit) begin
        pwm_period <= r_period;
        pwm_duty   <= w_duty_tick;
      end

      if (!pwm_rst_n) begin
        r_cnt <= 32'd0;
      end else if (r_cnt > pwm_period) begin
        r_cnt <= 32'd0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end

      irq <= r_irq_en && r_pend_irq;
    end
  end

  // --------------------------------------------------------------------------
  // Read path: sampled in the read cycle, presented one cycle later
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = 32'd0;
    case (avs_address)
      c_addr_ctrl:   w_rdata = {29'd0, r_irq_en, r_ramp_en, r_en};
      c_addr_period: w_rdata = r_period;
      c_addr_duty:   w_rdata = r_duty;
      c_addr_step:   w_rdata = r_step;
      c_addr_status: w_rdata = {29'd0, r_upd_pending, w_ramp_busy, r_pend_irq};
      c_addr_act_d:  w_rdata = pwm_duty;
      c_addr_act_p:  w_rdata = pwm_period;
      default:       w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata      <= 32'd0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= w_rdata;
      end
    end
  end

endmodule
`default_nettype wire
